kmer_match_stage: RTL

KMER_MATCH_STAGE -- requirements
Module: kmer_match_stage

---
 rtl/kmer_match_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/kmer_match_stage.sv
// Streaming k-mer matcher: shifts 2-bit bases into a K-base window and reports
// every full window whose mismatch count against the loaded pattern is within thr_mm.
module kmer_match_stage #(
  parameter int K     = 8,
  parameter int POS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pat_load,
  input  logic [2*K-1:0]   pat_data,
  input  logic             seq_start,
  input  logic [3:0]       thr_mm,
  input  logic             base_valid,
  input  logic [1:0]       base_in,
  output logic             base_ready,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [POS_W-1:0] hit_pos,
  output logic [3:0]       hit_mm,
  output logic             match_any
);

  localparam int W = 2 * K;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;

  localparam logic [3:0]       FILL_LAST = 4'(K - 1);
  localparam logic [POS_W-1:0] POS_BACK  = POS_W'(K - 1);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [W-1:0]     win_q, win_d;
  logic [3:0]       fill_q, fill_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             hit_valid_q, hit_valid_d;
  logic [POS_W-1:0] hit_pos_q, hit_pos_d;
  logic [3:0]       hit_mm_q, hit_mm_d;
  logic             match_any_q, match_any_d;

  logic [W-1:0]     win_shift_s;
  logic [3:0]       mm_cnt_s;
  logic             accept_s;
  logic             eval_s;
  logic             hit_s;

  function automatic logic [3:0] count_mm(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < K; i++) begin
      n = n + {3'd0, (a[2*i +: 2] != b[2*i +: 2])};
    end
    return n;
  endfunction

  // A pending, unconsumed hit stalls the base stream so no result is ever dropped.
  assign base_ready  = ~rst & (state_q != S_IDLE) & ~pat_load & ~seq_start &
                       (~hit_valid_q | hit_ready);
  assign accept_s    = base_valid & base_ready;
  assign win_shift_s = {win_q[W-3:0], base_in};
  assign mm_cnt_s    = count_mm(win_shift_s, pat_q);

  // Decide whether the base accepted this cycle completes a full window and hits.
  always_comb begin
    eval_s = 1'b0;
    case (state_q)
      S_FILL:  eval_s = accept_s & (fill_q == FILL_LAST);
      S_SCAN:  eval_s = accept_s;
      default: eval_s = 1'b0;
    endcase
    hit_s = eval_s & (mm_cnt_s <= thr_mm);
  end

  // Next-state logic for the scan FSM, window, counters and hit register.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    win_d       = win_q;
    fill_d      = fill_q;
    pos_d       = pos_q;
    hit_valid_d = hit_valid_q;
    hit_pos_d   = hit_pos_q;
    hit_mm_d    = hit_mm_q;
    match_any_d = match_any_q;

    if (pat_load) begin
      pat_d       = pat_data;
      win_d       = {W{1'b0}};
      fill_d      = 4'd0;
      pos_d       = {POS_W{1'b0}};
      hit_valid_d = 1'b0;
      match_any_d = 1'b0;
      state_d     = S_FILL;
    end else if (seq_start && (state_q != S_IDLE)) begin
      win_d       = {W{1'b0}};
      fill_d      = 4'd0;
      pos_d       = {POS_W{1'b0}};
      hit_valid_d = 1'b0;
      match_any_d = 1'b0;
      state_d     = S_FILL;
    end else begin
      if (accept_s) begin
        win_d = win_shift_s;
        pos_d = pos_q + POS_W'(1);
        if (state_q == S_FILL) begin
          fill_d  = fill_q + 4'd1;
          state_d = (fill_q == FILL_LAST) ? S_SCAN : S_FILL;
        end else begin
          fill_d  = fill_q;
          state_d = state_q;
        end
      end else begin
        win_d = win_q;
        pos_d = pos_q;
      end

      // A fresh hit overwrites a consumed one in the same cycle, leaving no gap.
      if (hit_s) begin
        hit_valid_d = 1'b1;
        hit_pos_d   = pos_q - POS_BACK;
        hit_mm_d    = mm_cnt_s;
        match_any_d = 1'b1;
      end else if (hit_ready) begin
        hit_valid_d = 1'b0;
      end else begin
        hit_valid_d = hit_valid_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pat_q       <= {W{1'b0}};
      win_q       <= {W{1'b0}};
      fill_q      <= 4'd0;
      pos_q       <= {POS_W{1'b0}};
      hit_valid_q <= 1'b0;
      hit_pos_q   <= {POS_W{1'b0}};
      hit_mm_q    <= 4'd0;
      match_any_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      win_q       <= win_d;
      fill_q      <= fill_d;
      pos_q       <= pos_d;
      hit_valid_q <= hit_valid_d;
      hit_pos_q   <= hit_pos_d;
      hit_mm_q    <= hit_mm_d;
      match_any_q <= match_any_d;
    end
  end

  assign hit_valid = hit_valid_q;
  assign hit_pos   = hit_pos_q;
  assign hit_mm    = hit_mm_q;
  assign match_any = match_any_q;

endmodule
